// File: rtl/domain_mux_arbiter.sv
// Round-robin arbiter/sequencer for a shared two-domain output mux.
// One domain owns the output at a time, for at most QUANTUM cycles while
// the other is waiting. Every domain switch goes through a SCRUB window
// that forces the output to zero, so D1 and D2 beats are never adjacent.
module domain_mux_arbiter #(
    parameter int WIDTH        = 8,
    parameter int QUANTUM      = 8,
    parameter int SCRUB_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_d1,
    input  logic             req_d2,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             gnt_d1,
    output logic             gnt_d2,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_dom
);

    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam int SW = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);
    localparam logic [SW-1:0] SMAX = SW'(SCRUB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SERVE_D1, SERVE_D2, SCRUB} state_t;

    state_t          state_q, state_n;
    logic [QW-1:0]   qcnt, qcnt_n;
    logic [SW-1:0]   scnt, scnt_n;
    logic            last_dom, last_n;   // 0 = D1, 1 = D2
    logic            gnt1_n, gnt2_n, sel_n, valid_n, dom_n;
    logic [WIDTH-1:0] data_n;

    // helper terms for the domain currently being served
    logic            serve_dom, req_own, req_oth, qsat;
    logic [WIDTH-1:0] d_own;
    logic            go, gdom;

    // State and all registered outputs; reset makes D1 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_d1    <= 1'b0;
            gnt_d2    <= 1'b0;
            sel       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_dom   <= 1'b0;
            qcnt      <= '0;
            scnt      <= '0;
            last_dom  <= 1'b1;
        end else begin
            state_q   <= state_n;
            gnt_d1    <= gnt1_n;
            gnt_d2    <= gnt2_n;
            sel       <= sel_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_dom   <= dom_n;
            qcnt      <= qcnt_n;
            scnt      <= scnt_n;
            last_dom  <= last_n;
        end
    end

    // Next-state, grant and output-beat selection.
    always_comb begin
        state_n = state_q;
        gnt1_n  = gnt_d1;
        gnt2_n  = gnt_d2;
        sel_n   = sel;
        data_n  = out_data;
        valid_n = out_valid;
        dom_n   = out_dom;
        qcnt_n  = qcnt;
        scnt_n  = scnt;
        last_n  = last_dom;
        go      = 1'b0;
        gdom    = 1'b0;

        serve_dom = (state_q == SERVE_D2);
        req_own   = serve_dom ? req_d2 : req_d1;
        req_oth   = serve_dom ? req_d1 : req_d2;
        d_own     = serve_dom ? d2 : d1;
        qsat      = (qcnt == QMAX);

        case (state_q)
            IDLE: begin
                // output is already zero here, so a grant needs no scrub
                data_n  = '0;
                valid_n = 1'b0;
                if (req_d1 || req_d2) begin
                    go   = 1'b1;
                    gdom = (req_d1 && req_d2) ? ~last_dom : req_d2;
                end
            end
            SERVE_D1, SERVE_D2: begin
                data_n  = req_own ? d_own : '0;
                valid_n = req_own;
                dom_n   = serve_dom;
                last_n  = serve_dom;
                qcnt_n  = qsat ? qcnt : qcnt + 1'b1;
                if (!req_own || (qsat && req_oth)) begin
                    gnt1_n  = 1'b0;
                    gnt2_n  = 1'b0;
                    scnt_n  = '0;
                    state_n = req_oth ? SCRUB : IDLE;
                end
            end
            SCRUB: begin
                // first SCRUB cycle still shows the last served beat;
                // everything after is forced to zero
                data_n  = '0;
                valid_n = 1'b0;
                if (scnt == SMAX) begin
                    // only the other domain may take over from a scrub
                    if (last_dom ? req_d1 : req_d2) begin
                        go   = 1'b1;
                        gdom = ~last_dom;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (go) begin
            state_n = gdom ? SERVE_D2 : SERVE_D1;
            gnt1_n  = ~gdom;
            gnt2_n  = gdom;
            sel_n   = gdom;
            qcnt_n  = '0;
        end
    end

endmodule

// File: tb/tb_domain_mux_arbiter.sv
// Directed and random checks of the two-domain arbiter, with per-cycle
// invariant checks on grant exclusivity and scrub separation.
module tb_domain_mux_arbiter;

    localparam int WIDTH        = 8;
    localparam int QUANTUM      = 8;
    localparam int SCRUB_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_d1 = 1'b0;
    logic             req_d2 = 1'b0;
    logic [WIDTH-1:0] d1 = '0;
    logic [WIDTH-1:0] d2 = '0;
    logic             gnt_d1, gnt_d2, sel, out_valid, out_dom;
    logic [WIDTH-1:0] out_data;

    int compared   = 0;
    int mismatched = 0;

    // separation tracking for the invariant monitor
    logic have_last = 1'b0;
    logic last_v    = 1'b0;
    int   gap       = 0;

    domain_mux_arbiter #(
        .WIDTH(WIDTH), .QUANTUM(QUANTUM), .SCRUB_CYCLES(SCRUB_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_d1(req_d1), .req_d2(req_d2),
        .d1(d1), .d2(d2), .gnt_d1(gnt_d1), .gnt_d2(gnt_d2), .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .out_dom(out_dom)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Invariants sampled once per cycle, away from the clock edge.
    task automatic inv();
        if (!rst_n) begin
            have_last = 1'b0;
            gap = 0;
            return;
        end
        chk("inv_gnt_excl", 32'(gnt_d1 && gnt_d2), 0);
        if (gnt_d1) chk("inv_sel_d1", 32'(sel), 0);
        if (gnt_d2) chk("inv_sel_d2", 32'(sel), 1);
        if (out_valid) begin
            if (have_last && (out_dom != last_v))
                chk("inv_scrub_gap", 32'(gap >= SCRUB_CYCLES - 1), 1);
            have_last = 1'b1;
            last_v    = out_dom;
            gap       = 0;
        end else begin
            chk("inv_zero_data", 32'(out_data), 0);
            gap++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        inv();
    endtask

    initial begin
        // ---- reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt_d1", 32'(gnt_d1), 0);
        chk("rst_gnt_d2", 32'(gnt_d2), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_dom", 32'(out_dom), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- single D1 request: grant latency 1, data latency 1 after grant
        req_d1 = 1'b1;
        d1     = 8'hA5;
        step();
        chk("t1_gnt_d1", 32'(gnt_d1), 1);
        chk("t1_sel", 32'(sel), 0);
        chk("t1_valid_pre", 32'(out_valid), 0);
        step();
        chk("t1_out_data", 32'(out_data), 'hA5);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_dom", 32'(out_dom), 0);

        // ---- D1 alone for 20 cycles: grant holds, no scrub
        for (int i = 0; i < 20; i++) begin
            d1 = 8'(i + 1);
            step();
            chk("t3_gnt_d1_hold", 32'(gnt_d1), 1);
            chk("t3_data_lat", 32'(out_data), 32'(i + 1));
        end

        // ---- D2 arrives with D1's quantum saturated: immediate preemption
        req_d2 = 1'b1;
        step();
        chk("t3_pre_gnt_d1", 32'(gnt_d1), 0);
        chk("t3_pre_gnt_d2", 32'(gnt_d2), 0);
        chk("t3_scrub1_valid", 32'(out_valid), 1);
        chk("t3_scrub1_data", 32'(out_data), 'h14);
        step();
        chk("t3_scrub2_data", 32'(out_data), 0);
        chk("t3_scrub2_valid", 32'(out_valid), 0);
        chk("t3_scrub2_dom", 32'(out_dom), 0);
        chk("t3_scrub2_gnt", 32'(gnt_d1 | gnt_d2), 0);
        step();
        chk("t2_gnt_d2", 32'(gnt_d2), 1);
        chk("t2_sel", 32'(sel), 1);
        chk("t2_gnt_d1", 32'(gnt_d1), 0);

        // ---- both requesting: D2 keeps the path for exactly QUANTUM cycles
        for (int i = 0; i < QUANTUM - 1; i++) begin
            d2 = 8'(8'h40 + i);
            step();
            chk("t2_gnt_d2_hold", 32'(gnt_d2), 1);
            chk("t2_d2_data", 32'(out_data), 32'(8'h40 + i));
            chk("t2_d2_dom", 32'(out_dom), 1);
        end
        step();
        chk("t2_q_end_gnt", 32'(gnt_d1 | gnt_d2), 0);
        chk("t2_q_end_valid", 32'(out_valid), 1);
        chk("t2_q_end_data", 32'(out_data), 'h46);
        step();
        chk("t2_scrub_data", 32'(out_data), 0);
        chk("t2_scrub_valid", 32'(out_valid), 0);
        chk("t2_scrub_dom", 32'(out_dom), 1);
        step();
        chk("t2_back_gnt_d1", 32'(gnt_d1), 1);
        chk("t2_back_sel", 32'(sel), 0);

        // ---- D1 drops while D2 waits: scrub then D2
        req_d1 = 1'b0;
        step();
        chk("t4_drop_gnt", 32'(gnt_d1 | gnt_d2), 0);
        chk("t4_drop_valid", 32'(out_valid), 0);
        step();
        step();
        chk("t4_d2_gnt", 32'(gnt_d2), 1);
        chk("t4_d2_sel", 32'(sel), 1);
        d2 = 8'h77;
        step();
        chk("t4_d2_data", 32'(out_data), 'h77);

        // ---- D2->D1 switch; D1 withdraws during scrub, D2 re-requests
        req_d1 = 1'b1;
        req_d2 = 1'b0;
        step();
        chk("t4_sw_gnt", 32'(gnt_d1 | gnt_d2), 0);
        req_d2 = 1'b1;
        req_d1 = 1'b0;
        step();
        chk("t4_scrub_gnt", 32'(gnt_d1 | gnt_d2), 0);
        step();
        chk("t4_idle_gnt", 32'(gnt_d1 | gnt_d2), 0);
        step();
        chk("t4_regrant_d2", 32'(gnt_d2), 1);
        chk("t4_regrant_d1", 32'(gnt_d1), 0);
        chk("t4_regrant_sel", 32'(sel), 1);

        // ---- asynchronous reset mid-serve
        d2 = 8'h3C;
        step();
        chk("t5_pre_data", 32'(out_data), 'h3C);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_gnt_d2", 32'(gnt_d2), 0);
        chk("t5_async_data", 32'(out_data), 0);
        chk("t5_async_valid", 32'(out_valid), 0);
        chk("t5_async_dom", 32'(out_dom), 0);
        chk("t5_async_sel", 32'(sel), 0);
        have_last = 1'b0;
        gap       = 0;
        req_d1    = 1'b1;
        req_d2    = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("t5_tie_gnt_d1", 32'(gnt_d1), 1);
        chk("t5_tie_gnt_d2", 32'(gnt_d2), 0);
        chk("t5_tie_sel", 32'(sel), 0);

        // ---- random traffic: invariants are checked every cycle
        for (int i = 0; i < 10000; i++) begin
            req_d1 = ($urandom_range(0, 3) != 0);
            req_d2 = ($urandom_range(0, 3) != 0);
            d1     = 8'($urandom);
            d2     = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/domain_mux_arbiter.md
Name: domain_mux_arbiter

Overview:
- Time-multiplexed arbiter and sequencer for a shared two-domain mux. Domain D1 and domain D2 each request use of the shared output path.
- The block drives the mux select. It grants one domain at a time, round-robin, with a bounded time quantum.
- Between any domain switch it inserts a scrub window in which the output is forced to zero. No D1 data is ever adjacent to D2 data on the shared output, which keeps label checking on the output path clean.
- Sits between the domain requesters and the shared datapath output of the secure I2C design.

Parameters:
- WIDTH, 8, data width of d1, d2, out_data.
- QUANTUM, 8, maximum consecutive serve cycles for one domain while the other domain is requesting; must be >= 1.
- SCRUB_CYCLES, 2, number of zero-output cycles inserted at each domain switch; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_d1  input  1  domain D1 requests the shared path.
- req_d2  input  1  domain D2 requests the shared path.
- d1  input  WIDTH  D1 data.
- d2  input  WIDTH  D2 data.
- gnt_d1  output  1  D1 currently granted (registered).
- gnt_d2  output  1  D2 currently granted (registered).
- sel  output  1  mux select, registered; 0 = D1, 1 = D2.
- out_data  output  WIDTH  registered shared output.
- out_valid  output  1  out_data holds a granted beat.
- out_dom  output  1  domain tag of out_data; 0 = D1, 1 = D2.

Behaviour:
- Reset (rst_n = 0, asynchronous, effective immediately, including mid-serve or mid-scrub):
  - state = IDLE; gnt_d1 = gnt_d2 = 0; sel = 0.
  - out_data = 0; out_valid = 0; out_dom = 0.
  - quantum counter = 0; scrub counter = 0.
  - last_dom = D2, so D1 wins the first tie.
- States: IDLE, SERVE_D1, SERVE_D2, SCRUB.
- IDLE:
  - Outputs are zero and no grant is asserted.
  - Only one request high: go to SERVE of that domain.
  - Both requests high: go to SERVE of the domain != last_dom.
  - No scrub is needed from IDLE, because the output is already zero.
- On entering SERVE_x: gnt_x = 1, sel = x and quantum counter = 0 in the same edge. Grant latency is one cycle after the request is sampled.
- SERVE_x, each cycle:
  - out_data <= req_x ? d_x : 0; out_valid <= req_x; out_dom <= x.
  - Data-in to data-out latency is exactly 1 cycle.
  - last_dom <= x.
  - Quantum counter increments, saturating at QUANTUM-1.
- Exit from SERVE_x, evaluated each cycle with priority in the order listed:
  - req_x = 0 and other domain requesting: go to SCRUB.
  - req_x = 0 and other domain idle: go to IDLE.
  - req_x = 1, counter == QUANTUM-1 and other domain requesting: go to SCRUB (preemption).
  - Otherwise stay in SERVE_x. If the quantum is expired and the other domain is idle, stay and hold the counter saturated.
- Entering SCRUB:
  - gnt_d1 = gnt_d2 = 0; sel holds its old value; scrub counter = 0.
  - The first SCRUB cycle still shows the final SERVE beat on out_data, tagged with the old out_dom.
  - From the second SCRUB cycle onward: out_data = 0, out_valid = 0, out_dom holds.
- SCRUB duration: SCRUB_CYCLES cycles. On the last one, target = the domain != last_dom.
  - Target requesting: go to SERVE_target, with sel and grant updated on the same edge.
  - Target not requesting: go to IDLE.
  - Requests from last_dom during SCRUB are ignored until IDLE.
- Invariants (both checked by assertions):
  - gnt_d1 and gnt_d2 are never high together.
  - Two out_valid beats with different out_dom are always separated by at least SCRUB_CYCLES-1 cycles with out_valid = 0 and out_data = 0.
- While gnt_x = 1, sel == x.
- The counters use width $clog2 of their parameter, minimum 1 bit.

Test Plan:
- Reset, then req_d1 = 1 with d1 = 8'hA5 -> gnt_d1 = 1 after 1 cycle; out_data = 8'hA5, out_valid = 1, out_dom = 0 one cycle after the grant.
- req_d1 and req_d2 held high from reset, QUANTUM = 8, SCRUB_CYCLES = 2 -> D1 granted for 8 cycles, then 2 grant-free cycles with the second having out_data = 0, then gnt_d2 = 1 and sel = 1 for 8 cycles; pattern repeats.
- D1 served, D2 idle for 20 cycles -> gnt_d1 stays 1 throughout; the counter saturates; no SCRUB is entered.
- D2 requests during the first SCRUB cycle of a D2→D1 switch, D1 drops its request -> after SCRUB the block goes to IDLE, then grants D2 from IDLE; no overlap of grants.
- rst_n pulsed low asynchronously mid-SERVE_D2 with out_data = 8'h3C -> all outputs go to 0 immediately without a clock edge; after release with both requesting, D1 is granted first.
- Random request/data stimulus for 10k cycles -> both invariant assertions never fire.
